// File: rtl/hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hazard_ctrl : RV32I 5-stage interlock, forwarding selects, MDU sequencing |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MDU_TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] IFID_d_inst,
  input  logic        IFID_c_valid,
  input  logic        ID_c_RegWEn,
  input  logic        ID_c_EnRDMem,
  input  logic        ID_c_MulDiv,
  input  logic        EX_c_redirect,
  input  logic        MDU_c_done,
  output logic        PC_c_stall,
  output logic        IFID_c_stall,
  output logic        IFID_c_flush,
  output logic        IDEX_c_bubble,
  output logic        MDU_c_start,
  output logic [1:0]  IDEX_c_FwdA,
  output logic [1:0]  IDEX_c_FwdB,
  output logic        HZ_c_mdu_err
);

  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int TCW = (MDU_TIMEOUT > 1) ? $clog2(MDU_TIMEOUT) : 1;
  localparam logic [FCW-1:0] FLUSH_INIT = FCW'(FLUSH_CYCLES - 1);
  localparam logic [FCW-1:0] FLUSH_ONE  = FCW'(1);
  localparam logic [TCW-1:0] TO_LAST    = TCW'(MDU_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    MDWAIT  = 2'd2,
    FLUSH   = 2'd3
  } state_t;

  state_t         state;
  logic [FCW-1:0] flush_cnt;
  logic [TCW-1:0] to_cnt;
  logic           mdu_ack;
  logic [1:0]     fwd_a;
  logic [1:0]     fwd_b;
  logic           mdu_err;

  logic       ex_valid, ex_wen, ex_load;
  logic [4:0] ex_rd;
  logic       mem_valid, mem_wen;
  logic [4:0] mem_rd;
  logic       wb_valid, wb_wen;
  logic [4:0] wb_rd;

  logic [4:0] rs1, rs2, rd;
  assign rs1 = IFID_d_inst[19:15];
  assign rs2 = IFID_d_inst[24:20];
  assign rd  = IFID_d_inst[11:7];

  logic unused_inst_bits;
  assign unused_inst_bits = ^{IFID_d_inst[31:25], IFID_d_inst[14:12], IFID_d_inst[6:0]};

  function automatic logic hit(input logic v, input logic wen, input logic [4:0] prd,
                               input logic [4:0] rs);
    return v & wen & (prd == rs) & (rs != 5'd0);
  endfunction

  // Youngest producer wins: EX slot now sits in MEM when the consumer reaches EX.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (hit(ex_valid, ex_wen, ex_rd, rs))         return 2'b01;
    else if (hit(mem_valid, mem_wen, mem_rd, rs)) return 2'b10;
    else if (hit(wb_valid, wb_wen, wb_rd, rs))    return 2'b11;
    else                                          return 2'b00;
  endfunction

  logic issue_state, take_redirect, load_use, do_ldstall, do_mdu;
  logic stall, flush, bubble;

  always_comb begin
    issue_state   = (state == RUN) || (state == LDSTALL);
    take_redirect = EX_c_redirect && (state != MDWAIT);
    load_use      = IFID_c_valid && ex_load &&
                    (hit(ex_valid, ex_wen, ex_rd, rs1) || hit(ex_valid, ex_wen, ex_rd, rs2));
    do_ldstall    = issue_state && !EX_c_redirect && load_use;
    // mdu_ack marks the ID op as already executed so it issues instead of restarting
    do_mdu        = issue_state && !EX_c_redirect && !load_use && IFID_c_valid &&
                    ID_c_MulDiv && !mdu_ack;
    stall         = do_ldstall || do_mdu || (state == MDWAIT);
    flush         = take_redirect || ((state == FLUSH) && (flush_cnt != '0));
    bubble        = stall || flush;
  end

  assign PC_c_stall    = rst_n & stall;
  assign IFID_c_stall  = rst_n & stall;
  assign IFID_c_flush  = rst_n & flush;
  assign IDEX_c_bubble = rst_n & bubble;
  assign MDU_c_start   = rst_n & do_mdu;
  assign IDEX_c_FwdA   = fwd_a;
  assign IDEX_c_FwdB   = fwd_b;
  assign HZ_c_mdu_err  = mdu_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      flush_cnt <= '0;
      to_cnt    <= '0;
      mdu_ack   <= 1'b0;
      fwd_a     <= 2'b00;
      fwd_b     <= 2'b00;
      mdu_err   <= 1'b0;
      ex_valid  <= 1'b0;
      ex_wen    <= 1'b0;
      ex_load   <= 1'b0;
      ex_rd     <= 5'd0;
      mem_valid <= 1'b0;
      mem_wen   <= 1'b0;
      mem_rd    <= 5'd0;
      wb_valid  <= 1'b0;
      wb_wen    <= 1'b0;
      wb_rd     <= 5'd0;
    end else begin
      ex_valid  <= IFID_c_valid && !bubble;
      ex_wen    <= ID_c_RegWEn;
      ex_load   <= ID_c_EnRDMem;
      ex_rd     <= rd;
      mem_valid <= ex_valid;
      mem_wen   <= ex_wen;
      mem_rd    <= ex_rd;
      wb_valid  <= mem_valid;
      wb_wen    <= mem_wen;
      wb_rd     <= mem_rd;

      if (bubble || !IFID_c_valid) begin
        fwd_a <= 2'b00;
        fwd_b <= 2'b00;
      end else begin
        fwd_a <= fwd_sel(rs1);
        fwd_b <= fwd_sel(rs2);
      end

      mdu_ack <= 1'b0;
      case (state)
        RUN, LDSTALL: begin
          if (take_redirect) begin
            flush_cnt <= FLUSH_INIT;
            state     <= (FLUSH_CYCLES > 1) ? FLUSH : RUN;
          end else if (do_ldstall) begin
            state <= LDSTALL;
          end else if (do_mdu) begin
            to_cnt <= '0;
            state  <= MDWAIT;
          end else begin
            state <= RUN;
          end
        end
        MDWAIT: begin
          if (MDU_c_done) begin
            mdu_ack <= 1'b1;
            state   <= RUN;
          end else if (to_cnt == TO_LAST) begin
            mdu_err <= 1'b1;
            mdu_ack <= 1'b1;
            state   <= RUN;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        FLUSH: begin
          if (take_redirect) begin
            flush_cnt <= FLUSH_INIT;
          end else if (flush_cnt <= FLUSH_ONE) begin
            flush_cnt <= '0;
            state     <= RUN;
          end else begin
            flush_cnt <= flush_cnt - 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_hazard_ctrl : directed-vector scoreboard bench for hazard_ctrl         |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] inst;
  logic        valid, wen, isload, muldiv, redirect, done;
  logic        pc_stall, ifid_stall, flush, bubble, start, mdu_err;
  logic [1:0]  fwd_a, fwd_b;

  hazard_ctrl #(.FLUSH_CYCLES(2), .MDU_TIMEOUT(64)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .IFID_d_inst   (inst),
    .IFID_c_valid  (valid),
    .ID_c_RegWEn   (wen),
    .ID_c_EnRDMem  (isload),
    .ID_c_MulDiv   (muldiv),
    .EX_c_redirect (redirect),
    .MDU_c_done    (done),
    .PC_c_stall    (pc_stall),
    .IFID_c_stall  (ifid_stall),
    .IFID_c_flush  (flush),
    .IDEX_c_bubble (bubble),
    .MDU_c_start   (start),
    .IDEX_c_FwdA   (fwd_a),
    .IDEX_c_FwdB   (fwd_b),
    .HZ_c_mdu_err  (mdu_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  string      nm_q[$];
  logic [9:0] exp_q[$];
  int         total = 0;
  int         bad   = 0;

  // {pc_stall, ifid_stall, flush, bubble, start, fwd_a, fwd_b, err}
  function automatic logic [9:0] E(input logic st, input logic fl, input logic bu,
                                   input logic sa, input logic [1:0] fa,
                                   input logic [1:0] fb, input logic er);
    return {st, st, fl, bu, sa, fa, fb, er};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] a,
                                        input logic [4:0] b);
    return {7'b0000000, b, a, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] mext(input logic [2:0] f3, input logic [4:0] rd,
                                       input logic [4:0] a, input logic [4:0] b);
    return {7'b0000001, b, a, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] a);
    return {12'd0, a, 3'b010, rd, 7'b0000011};
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] a,
                                       input logic [11:0] imm);
    return {imm, a, 3'b000, rd, 7'b0010011};
  endfunction

  task automatic cyc(input string nm, input logic r, input logic [31:0] i,
                     input logic v, input logic w, input logic l, input logic m,
                     input logic rd_i, input logic dn, input logic [9:0] e);
    @(posedge clk);
    #1;
    rst_n    = r;
    inst     = i;
    valid    = v;
    wen      = w;
    isload   = l;
    muldiv   = m;
    redirect = rd_i;
    done     = dn;
    nm_q.push_back(nm);
    exp_q.push_back(e);
  endtask

  task automatic idle(input string nm, input logic rd_i, input logic [9:0] e);
    cyc(nm, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, rd_i, 1'b0, e);
  endtask

  logic [9:0] act_v, exp_v;
  string      cur_nm;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur_nm = nm_q.pop_front();
      exp_v  = exp_q.pop_front();
      act_v  = {pc_stall, ifid_stall, flush, bubble, start, fwd_a, fwd_b, mdu_err};
      total++;
      if (act_v !== exp_v) begin
        bad++;
        $display("FAIL %s: got %b want %b (stall,stall,flush,bubble,start,fa,fb,err)",
                 cur_nm, act_v, exp_v);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  logic [9:0] Z;
  logic [31:0] mul_i, div_i, mul2_i;

  initial begin
    Z      = E(0, 0, 0, 0, 2'b00, 2'b00, 0);
    mul_i  = mext(3'b000, 5'd12, 5'd1, 5'd2);
    div_i  = mext(3'b100, 5'd14, 5'd1, 5'd2);
    mul2_i = mext(3'b000, 5'd15, 5'd1, 5'd2);
    rst_n = 1'b0; inst = '0; valid = 0; wen = 0; isload = 0; muldiv = 0;
    redirect = 0; done = 0;

    // Reset with an MDU op sitting in ID: everything must stay quiet.
    cyc("rst0", 0, mul_i, 1, 1, 0, 1, 0, 0, Z);
    cyc("rst1", 0, mul_i, 1, 1, 0, 1, 0, 0, Z);

    // Load-use: lw x5 then add x6,x5,x2.
    cyc("ld_issue", 1, lw(5'd5, 5'd1), 1, 1, 1, 0, 0, 0, Z);
    cyc("ld_use", 1, rtype(5'd6, 5'd5, 5'd2), 1, 1, 0, 0, 0, 0, E(1, 0, 1, 0, 2'b00, 2'b00, 0));
    cyc("ld_release", 1, rtype(5'd6, 5'd5, 5'd2), 1, 1, 0, 0, 0, 0, Z);
    idle("ld_fwd", 0, E(0, 0, 0, 0, 2'b10, 2'b00, 0));
    idle("ld_drain0", 0, Z);
    idle("ld_drain1", 0, Z);

    // ALU chain: addi x3; addi x4; add x7,x3,x4.
    cyc("alu_addi3", 1, addi(5'd3, 5'd0, 12'd1), 1, 1, 0, 0, 0, 0, Z);
    cyc("alu_addi4", 1, addi(5'd4, 5'd0, 12'd2), 1, 1, 0, 0, 0, 0, Z);
    cyc("alu_add7", 1, rtype(5'd7, 5'd3, 5'd4), 1, 1, 0, 0, 0, 0, Z);
    idle("alu_fwd", 0, E(0, 0, 0, 0, 2'b10, 2'b01, 0));
    // x0 producer followed by an x0 consumer: no forwarding.
    cyc("x0_prod", 1, rtype(5'd0, 5'd1, 5'd2), 1, 1, 0, 0, 0, 0, Z);
    cyc("x0_cons", 1, rtype(5'd9, 5'd0, 5'd0), 1, 1, 0, 0, 0, 0, Z);
    idle("x0_fwd", 0, Z);
    idle("wb_gap", 0, Z);
    // x9 now in WB slot -> WB bypass.
    cyc("wb_cons", 1, rtype(5'd10, 5'd9, 5'd0), 1, 1, 0, 0, 0, 0, Z);
    idle("wb_fwd", 0, E(0, 0, 0, 0, 2'b11, 2'b00, 0));
    idle("wb_drain0", 0, Z);
    idle("wb_drain1", 0, Z);

    // Two producers of x3 in flight: youngest (EX) wins.
    cyc("young_p1", 1, rtype(5'd3, 5'd0, 5'd0), 1, 1, 0, 0, 0, 0, Z);
    cyc("young_p2", 1, rtype(5'd3, 5'd0, 5'd0), 1, 1, 0, 0, 0, 0, Z);
    cyc("young_cons", 1, rtype(5'd11, 5'd3, 5'd3), 1, 1, 0, 0, 0, 0, Z);
    idle("young_fwd", 0, E(0, 0, 0, 0, 2'b01, 2'b01, 0));
    idle("young_drain0", 0, Z);
    idle("young_drain1", 0, Z);

    // Redirect with a load-use pending: flush wins, 2 flush cycles, no stall.
    cyc("rd_lw", 1, lw(5'd5, 5'd1), 1, 1, 1, 0, 0, 0, Z);
    cyc("rd_flush0", 1, rtype(5'd6, 5'd5, 5'd2), 1, 1, 0, 0, 1, 0, E(0, 1, 1, 0, 2'b00, 2'b00, 0));
    cyc("rd_flush1", 1, rtype(5'd6, 5'd5, 5'd2), 1, 1, 0, 0, 0, 0, E(0, 1, 1, 0, 2'b00, 2'b00, 0));
    idle("rd_done", 0, Z);

    // Redirect during FLUSH reloads the counter.
    idle("rl_flush0", 1, E(0, 1, 1, 0, 2'b00, 2'b00, 0));
    idle("rl_reload", 1, E(0, 1, 1, 0, 2'b00, 2'b00, 0));
    idle("rl_flush2", 0, E(0, 1, 1, 0, 2'b00, 2'b00, 0));
    idle("rl_done", 0, Z);

    // mul x12: start pulse, 5 stall cycles, then issue.
    cyc("mul_start", 1, mul_i, 1, 1, 0, 1, 0, 0, E(1, 0, 1, 1, 2'b00, 2'b00, 0));
    for (int k = 0; k < 3; k++)
      cyc("mul_wait", 1, mul_i, 1, 1, 0, 1, 0, 0, E(1, 0, 1, 0, 2'b00, 2'b00, 0));
    cyc("mul_done", 1, mul_i, 1, 1, 0, 1, 0, 1, E(1, 0, 1, 0, 2'b00, 2'b00, 0));
    cyc("mul_issue", 1, mul_i, 1, 1, 0, 1, 0, 0, Z);
    cyc("mul_cons", 1, rtype(5'd13, 5'd12, 5'd0), 1, 1, 0, 0, 0, 0, Z);
    idle("mul_fwd", 0, E(0, 0, 0, 0, 2'b01, 2'b00, 0));
    idle("mul_drain0", 0, Z);
    idle("mul_drain1", 0, Z);

    // div with no done: 1 + 64 stall cycles, then sticky error and release.
    cyc("div_start", 1, div_i, 1, 1, 0, 1, 0, 0, E(1, 0, 1, 1, 2'b00, 2'b00, 0));
    for (int k = 0; k < 64; k++)
      cyc("div_wait", 1, div_i, 1, 1, 0, 1, 0, 0, E(1, 0, 1, 0, 2'b00, 2'b00, 0));
    cyc("div_timeout", 1, div_i, 1, 1, 0, 1, 0, 0, E(0, 0, 0, 0, 2'b00, 2'b00, 1));
    idle("div_err_sticky", 0, E(0, 0, 0, 0, 2'b00, 2'b00, 1));

    // Reset asserted mid-MDWAIT.
    cyc("rm_start", 1, mul2_i, 1, 1, 0, 1, 0, 0, E(1, 0, 1, 1, 2'b00, 2'b00, 1));
    cyc("rm_wait0", 1, mul2_i, 1, 1, 0, 1, 0, 0, E(1, 0, 1, 0, 2'b00, 2'b00, 1));
    cyc("rm_wait1", 1, mul2_i, 1, 1, 0, 1, 0, 0, E(1, 0, 1, 0, 2'b00, 2'b00, 1));
    cyc("rm_assert", 0, mul2_i, 1, 1, 0, 1, 0, 0, Z);
    cyc("rm_hold", 0, mul2_i, 1, 1, 0, 1, 0, 0, Z);
    idle("rm_release", 0, Z);
    idle("rm_run", 0, Z);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
